// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite interconnect.
//   RESP_*       : AXI response encodings
//   w_state_e    : write engine states
//   r_state_e    : read engine states
//   addr_decode  : one-hot slot decode; the lowest matching slot wins
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Decode operands are zero-padded to these maxima so one function serves
   // every parameterisation of the interconnect.
   localparam int MAX_M  = 16;
   localparam int MAX_AW = 64;

   typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_e;

   function automatic logic [MAX_M-1:0] addr_decode(
      input logic [MAX_AW-1:0]       addr,
      input logic [MAX_M*MAX_AW-1:0] bases,
      input logic [MAX_M*32-1:0]     bits,
      input int                      num_m
   );
      logic [MAX_M-1:0] hit;
      hit = '0;
      // Walk downwards so the lowest matching slot is the one left standing.
      for (int m = MAX_M - 1; m >= 0; m--) begin
         if (m < num_m) begin
            if ((addr >> bits[m*32 +: 32]) ==
                (bases[m*MAX_AW +: MAX_AW] >> bits[m*32 +: 32])) begin
               hit = MAX_M'(1) << m;
            end
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter.
//   aclk, areset : clock, asynchronous active-high reset
//   req          : request vector
//   advance      : grant accepted; move the pointer to the current winner
//   grant_onehot : combinational one-hot winner (0 when nothing requests)
//   grant_idx    : binary index of the winner
module axi_lite_rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] last_q, last_d;
   logic          found;
   logic [N-1:0]  req_rot;
   int            cand;

   // The search starts one past the last grant and wraps modulo N.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      cand         = 0;
      req_rot      = '0;
      for (int k = 1; k <= N; k++) begin
         cand    = (int'(last_q) + k) % N;
         req_rot = req >> cand;
         if (!found && req_rot[0]) begin
            found        = 1'b1;
            grant_onehot = N'(1) << cand;
            grant_idx    = IW'(cand);
         end
      end
      last_d = (advance && found) ? grant_idx : last_q;
   end

   // Reset to N-1 so slot 0 is examined first.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) last_q <= IW'(N - 1);
      else        last_q <= last_d;
   end

endmodule

// File: rtl/axi_lite_interconnect.sv
// AXI4-Lite NUM_S-to-NUM_M interconnect with independent write and read
// engines, each carrying one transaction at a time.
//   aclk, areset  : clock, asynchronous active-high reset
//   s_axi_*       : upstream ports, NUM_S slots, slot-major flattened
//   m_axi_*       : downstream ports, NUM_M slots, slot-major flattened
// Unmapped addresses are answered locally with DECERR.
//
// state  | meaning
// W_IDLE | arbitrate AW among upstream slots
// W_FWD  | present AW downstream, pass W through
// W_RESP | pass B from target back to winner
// W_ERR  | swallow W, then answer DECERR
// R_IDLE | arbitrate AR among upstream slots
// R_FWD  | present AR downstream
// R_RESP | pass R from target back to winner
// R_ERR  | answer DECERR with zero data
module axi_lite_interconnect
   import axi_lite_pkg::*;
#(
   parameter int                          NUM_S       = 2,
   parameter int                          NUM_M       = 2,
   parameter int                          ADDR_WIDTH  = 32,
   parameter int                          DATA_WIDTH  = 32,
   parameter logic [NUM_M*ADDR_WIDTH-1:0] M_BASE_ADDR = {32'h0000_1000, 32'h0000_0000},
   parameter logic [NUM_M*32-1:0]         M_ADDR_BITS = {32'd12, 32'd12}
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [NUM_S*ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic [NUM_S*3-1:0]           s_axi_awprot,
   input  logic [NUM_S-1:0]             s_axi_awvalid,
   output logic [NUM_S-1:0]             s_axi_awready,
   input  logic [NUM_S*DATA_WIDTH-1:0]  s_axi_wdata,
   input  logic [NUM_S*DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic [NUM_S-1:0]             s_axi_wvalid,
   output logic [NUM_S-1:0]             s_axi_wready,
   output logic [NUM_S*2-1:0]           s_axi_bresp,
   output logic [NUM_S-1:0]             s_axi_bvalid,
   input  logic [NUM_S-1:0]             s_axi_bready,
   input  logic [NUM_S*ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic [NUM_S*3-1:0]           s_axi_arprot,
   input  logic [NUM_S-1:0]             s_axi_arvalid,
   output logic [NUM_S-1:0]             s_axi_arready,
   output logic [NUM_S*DATA_WIDTH-1:0]  s_axi_rdata,
   output logic [NUM_S*2-1:0]           s_axi_rresp,
   output logic [NUM_S-1:0]             s_axi_rvalid,
   input  logic [NUM_S-1:0]             s_axi_rready,
   output logic [NUM_M*ADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic [NUM_M*3-1:0]           m_axi_awprot,
   output logic [NUM_M-1:0]             m_axi_awvalid,
   input  logic [NUM_M-1:0]             m_axi_awready,
   output logic [NUM_M*DATA_WIDTH-1:0]  m_axi_wdata,
   output logic [NUM_M*DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic [NUM_M-1:0]             m_axi_wvalid,
   input  logic [NUM_M-1:0]             m_axi_wready,
   input  logic [NUM_M*2-1:0]           m_axi_bresp,
   input  logic [NUM_M-1:0]             m_axi_bvalid,
   output logic [NUM_M-1:0]             m_axi_bready,
   output logic [NUM_M*ADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [NUM_M*3-1:0]           m_axi_arprot,
   output logic [NUM_M-1:0]             m_axi_arvalid,
   input  logic [NUM_M-1:0]             m_axi_arready,
   input  logic [NUM_M*DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic [NUM_M*2-1:0]           m_axi_rresp,
   input  logic [NUM_M-1:0]             m_axi_rvalid,
   output logic [NUM_M-1:0]             m_axi_rready
);

   localparam int S_IW   = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam int M_IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int STRB_W = DATA_WIDTH / 8;

   // ---------------------------------------------------------------- arbiters
   logic [NUM_S-1:0] aw_grant_oh, ar_grant_oh;
   logic [S_IW-1:0]  aw_grant_idx, ar_grant_idx;
   logic             aw_advance, ar_advance;

   axi_lite_rr_arbiter #(.N(NUM_S)) u_aw_arb (
      .aclk(aclk), .areset(areset), .req(s_axi_awvalid), .advance(aw_advance),
      .grant_onehot(aw_grant_oh), .grant_idx(aw_grant_idx)
   );

   axi_lite_rr_arbiter #(.N(NUM_S)) u_ar_arb (
      .aclk(aclk), .areset(areset), .req(s_axi_arvalid), .advance(ar_advance),
      .grant_onehot(ar_grant_oh), .grant_idx(ar_grant_idx)
   );

   // ----------------------------------------------------------------- decode
   logic [MAX_M*MAX_AW-1:0] base_pad;
   logic [MAX_M*32-1:0]     bits_pad;
   logic [MAX_M-1:0]        aw_hit, ar_hit;
   logic [M_IW-1:0]         aw_tidx, ar_tidx;
   logic                    aw_match, ar_match;

   always_comb begin
      base_pad = '0;
      bits_pad = '0;
      for (int m = 0; m < NUM_M; m++) begin
         base_pad[m*MAX_AW +: MAX_AW] = MAX_AW'(M_BASE_ADDR[m*ADDR_WIDTH +: ADDR_WIDTH]);
         bits_pad[m*32 +: 32]         = M_ADDR_BITS[m*32 +: 32];
      end
      aw_hit = addr_decode(MAX_AW'(s_axi_awaddr[aw_grant_idx*ADDR_WIDTH +: ADDR_WIDTH]),
                           base_pad, bits_pad, NUM_M);
      ar_hit = addr_decode(MAX_AW'(s_axi_araddr[ar_grant_idx*ADDR_WIDTH +: ADDR_WIDTH]),
                           base_pad, bits_pad, NUM_M);
      aw_tidx = '0;
      ar_tidx = '0;
      for (int m = 0; m < NUM_M; m++) begin
         if (aw_hit[m]) aw_tidx = M_IW'(m);
         if (ar_hit[m]) ar_tidx = M_IW'(m);
      end
   end

   assign aw_match = |aw_hit;
   assign ar_match = |ar_hit;

   // ----------------------------------------------------------- write engine
   w_state_e                w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
   logic [2:0]              aw_prot_q, aw_prot_d;
   logic [S_IW-1:0]         w_sidx_q, w_sidx_d;
   logic [M_IW-1:0]         w_midx_q, w_midx_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;

   // Address and data fan out to every downstream slot; only valid is steered.
   assign m_axi_awaddr = {NUM_M{aw_addr_q}};
   assign m_axi_awprot = {NUM_M{aw_prot_q}};
   assign m_axi_wdata  = {NUM_M{s_axi_wdata[w_sidx_q*DATA_WIDTH +: DATA_WIDTH]}};
   assign m_axi_wstrb  = {NUM_M{s_axi_wstrb[w_sidx_q*STRB_W +: STRB_W]}};

   always_comb begin
      w_state_d     = w_state_q;
      aw_addr_d     = aw_addr_q;
      aw_prot_d     = aw_prot_q;
      w_sidx_d      = w_sidx_q;
      w_midx_d      = w_midx_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      aw_advance    = 1'b0;
      s_axi_awready = '0;
      s_axi_wready  = '0;
      s_axi_bvalid  = '0;
      s_axi_bresp   = '0;
      m_axi_awvalid = '0;
      m_axi_wvalid  = '0;
      m_axi_bready  = '0;
      case (w_state_q)
         W_IDLE: begin
            // Gated by areset so no ready escapes while reset is held.
            if (|s_axi_awvalid && !areset) begin
               s_axi_awready = aw_grant_oh;
               aw_advance    = 1'b1;
               aw_addr_d     = s_axi_awaddr[aw_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               aw_prot_d     = s_axi_awprot[aw_grant_idx*3 +: 3];
               w_sidx_d      = aw_grant_idx;
               w_midx_d      = aw_tidx;
               aw_done_d     = 1'b0;
               w_done_d      = 1'b0;
               w_state_d     = aw_match ? W_FWD : W_ERR;
            end
         end
         W_FWD: begin
            m_axi_awvalid[w_midx_q] = !aw_done_q;
            m_axi_wvalid[w_midx_q]  = s_axi_wvalid[w_sidx_q] && !w_done_q;
            s_axi_wready[w_sidx_q]  = m_axi_wready[w_midx_q] && !w_done_q;
            if (!aw_done_q && m_axi_awready[w_midx_q]) aw_done_d = 1'b1;
            if (!w_done_q && s_axi_wvalid[w_sidx_q] && m_axi_wready[w_midx_q]) w_done_d = 1'b1;
            if (aw_done_d && w_done_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            s_axi_bvalid[w_sidx_q]          = m_axi_bvalid[w_midx_q];
            s_axi_bresp[w_sidx_q*2 +: 2]    = m_axi_bresp[w_midx_q*2 +: 2];
            m_axi_bready[w_midx_q]          = s_axi_bready[w_sidx_q];
            if (m_axi_bvalid[w_midx_q] && s_axi_bready[w_sidx_q]) w_state_d = W_IDLE;
         end
         W_ERR: begin
            // w_done_q separates the data-sink phase from the response phase.
            if (!w_done_q) begin
               s_axi_wready[w_sidx_q] = 1'b1;
               if (s_axi_wvalid[w_sidx_q]) w_done_d = 1'b1;
            end else begin
               s_axi_bvalid[w_sidx_q]       = 1'b1;
               s_axi_bresp[w_sidx_q*2 +: 2] = RESP_DECERR;
               if (s_axi_bready[w_sidx_q]) w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= W_IDLE;
         aw_addr_q <= '0;
         aw_prot_q <= '0;
         w_sidx_q  <= '0;
         w_midx_q  <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_addr_q <= aw_addr_d;
         aw_prot_q <= aw_prot_d;
         w_sidx_q  <= w_sidx_d;
         w_midx_q  <= w_midx_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // ------------------------------------------------------------ read engine
   r_state_e                r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
   logic [2:0]              ar_prot_q, ar_prot_d;
   logic [S_IW-1:0]         r_sidx_q, r_sidx_d;
   logic [M_IW-1:0]         r_midx_q, r_midx_d;

   assign m_axi_araddr = {NUM_M{ar_addr_q}};
   assign m_axi_arprot = {NUM_M{ar_prot_q}};

   always_comb begin
      r_state_d     = r_state_q;
      ar_addr_d     = ar_addr_q;
      ar_prot_d     = ar_prot_q;
      r_sidx_d      = r_sidx_q;
      r_midx_d      = r_midx_q;
      ar_advance    = 1'b0;
      s_axi_arready = '0;
      s_axi_rvalid  = '0;
      s_axi_rresp   = '0;
      s_axi_rdata   = '0;
      m_axi_arvalid = '0;
      m_axi_rready  = '0;
      case (r_state_q)
         R_IDLE: begin
            if (|s_axi_arvalid && !areset) begin
               s_axi_arready = ar_grant_oh;
               ar_advance    = 1'b1;
               ar_addr_d     = s_axi_araddr[ar_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               ar_prot_d     = s_axi_arprot[ar_grant_idx*3 +: 3];
               r_sidx_d      = ar_grant_idx;
               r_midx_d      = ar_tidx;
               r_state_d     = ar_match ? R_FWD : R_ERR;
            end
         end
         R_FWD: begin
            m_axi_arvalid[r_midx_q] = 1'b1;
            if (m_axi_arready[r_midx_q]) r_state_d = R_RESP;
         end
         R_RESP: begin
            s_axi_rvalid[r_sidx_q]                        = m_axi_rvalid[r_midx_q];
            s_axi_rresp[r_sidx_q*2 +: 2]                  = m_axi_rresp[r_midx_q*2 +: 2];
            s_axi_rdata[r_sidx_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata[r_midx_q*DATA_WIDTH +: DATA_WIDTH];
            m_axi_rready[r_midx_q]                        = s_axi_rready[r_sidx_q];
            if (m_axi_rvalid[r_midx_q] && s_axi_rready[r_sidx_q]) r_state_d = R_IDLE;
         end
         R_ERR: begin
            s_axi_rvalid[r_sidx_q]       = 1'b1;
            s_axi_rresp[r_sidx_q*2 +: 2] = RESP_DECERR;
            if (s_axi_rready[r_sidx_q]) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         ar_addr_q <= '0;
         ar_prot_q <= '0;
         r_sidx_q  <= '0;
         r_midx_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         ar_addr_q <= ar_addr_d;
         ar_prot_q <= ar_prot_d;
         r_sidx_q  <= r_sidx_d;
         r_midx_q  <= r_midx_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_interconnect.sv
module tb_axi_lite_interconnect;
   import axi_lite_pkg::*;

   logic        aclk, areset;
   logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
   logic [5:0]  s_awprot, s_arprot;
   logic [7:0]  s_wstrb;
   logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
   logic [3:0]  s_bresp, s_rresp;
   logic [63:0] m_awaddr, m_araddr, m_wdata, m_rdata;
   logic [5:0]  m_awprot, m_arprot;
   logic [7:0]  m_wstrb;
   logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
   logic [3:0]  m_bresp, m_rresp;

   int n_assert = 0;
   int n_fail   = 0;

   axi_lite_interconnect dut (
      .aclk(aclk), .areset(areset),
      .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
      .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
      .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
      .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
      .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
      .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
      .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
      .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
      .m_axi_araddr(m_araddr), .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
      .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_inputs();
      s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0;
      s_wvalid = '0; s_bready = '0; s_araddr = '0; s_arprot = '0; s_arvalid = '0;
      s_rready = '0; m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
      m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      areset = 1'b1;
      #2;
      areset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      areset    = 1'b1;
      s_awvalid = 2'b01;
      s_arvalid = 2'b10;
      #2;
      n_assert++; if (s_awready !== 2'b00) begin $display("FAIL reset_awready got=%b exp=00", s_awready); n_fail++; end
      n_assert++; if (s_arready !== 2'b00) begin $display("FAIL reset_arready got=%b exp=00", s_arready); n_fail++; end
      n_assert++; if (m_awvalid !== 2'b00 || m_arvalid !== 2'b00) begin $display("FAIL reset_m_valid got=%b/%b exp=00/00", m_awvalid, m_arvalid); n_fail++; end
      n_assert++; if (m_awaddr !== 64'h0 || m_araddr !== 64'h0 || m_awprot !== 6'h0) begin $display("FAIL reset_m_addr got=%h/%h exp=0", m_awaddr, m_araddr); n_fail++; end
      n_assert++; if (s_bvalid !== 2'b00 || s_rvalid !== 2'b00) begin $display("FAIL reset_s_resp got=%b/%b exp=00/00", s_bvalid, s_rvalid); n_fail++; end
      clear_inputs();
      tick();
      areset = 1'b0;
      tick();
   endtask

   task automatic test_write_basic();
      s_awaddr[31:0] = 32'h0000_1004; s_awvalid = 2'b01;
      s_wdata[31:0]  = 32'hDEADBEEF;  s_wstrb[3:0] = 4'hF; s_wvalid = 2'b01;
      s_bready = 2'b01;
      #1;
      n_assert++; if (s_awready !== 2'b01) begin $display("FAIL basic_awready got=%b exp=01", s_awready); n_fail++; end
      n_assert++; if (s_wready !== 2'b00) begin $display("FAIL basic_early_wready got=%b exp=00", s_wready); n_fail++; end
      tick();
      s_awvalid = 2'b00;
      #1;
      n_assert++; if (m_awvalid !== 2'b10) begin $display("FAIL basic_m_awvalid got=%b exp=10", m_awvalid); n_fail++; end
      n_assert++; if (m_awaddr[63:32] !== 32'h0000_1004) begin $display("FAIL basic_m_awaddr got=%h exp=00001004", m_awaddr[63:32]); n_fail++; end
      n_assert++; if (m_wvalid !== 2'b10 || m_wdata[63:32] !== 32'hDEADBEEF || m_wstrb[7:4] !== 4'hF)
         begin $display("FAIL basic_m_w got=%b/%h/%h exp=10/deadbeef/f", m_wvalid, m_wdata[63:32], m_wstrb[7:4]); n_fail++; end
      m_awready = 2'b10; m_wready = 2'b10;
      #1;
      n_assert++; if (s_wready !== 2'b01) begin $display("FAIL basic_s_wready got=%b exp=01", s_wready); n_fail++; end
      tick();
      m_awready = 2'b00; m_wready = 2'b00; s_wvalid = 2'b00;
      m_bvalid = 2'b10; m_bresp = {RESP_OKAY, RESP_DECERR};
      #1;
      n_assert++; if (m_awvalid !== 2'b00) begin $display("FAIL basic_awvalid_dropped got=%b exp=00", m_awvalid); n_fail++; end
      n_assert++; if (s_bvalid !== 2'b01 || s_bresp !== 4'b0000 || m_bready !== 2'b10)
         begin $display("FAIL basic_b got=%b/%b/%b exp=01/0000/10", s_bvalid, s_bresp, m_bready); n_fail++; end
      tick();
      m_bvalid = 2'b00;
      #1;
      n_assert++; if (s_bvalid !== 2'b00 || dut.w_state_q !== W_IDLE) begin $display("FAIL basic_done got=%b/%0d exp=00/0", s_bvalid, dut.w_state_q); n_fail++; end
      clear_inputs();
   endtask

   task automatic test_rr_alternate();
      logic [1:0]  exp_oh;
      logic [31:0] exp_addr;
      apply_reset();
      s_awaddr  = {32'h0000_1020, 32'h0000_0010};
      s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
      m_awready = 2'b11; m_wready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_1020;
         m_bvalid = 2'b00;
         #1;
         n_assert++; if (s_awready !== exp_oh) begin $display("FAIL rr_grant k=%0d got=%b exp=%b", k, s_awready, exp_oh); n_fail++; end
         tick();
         n_assert++; if (m_awvalid !== exp_oh || m_awaddr[31:0] !== exp_addr)
            begin $display("FAIL rr_fwd k=%0d got=%b/%h exp=%b/%h", k, m_awvalid, m_awaddr[31:0], exp_oh, exp_addr); n_fail++; end
         tick();
         m_bvalid = exp_oh;
         #1;
         n_assert++; if (s_bvalid !== exp_oh) begin $display("FAIL rr_b k=%0d got=%b exp=%b", k, s_bvalid, exp_oh); n_fail++; end
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_read_decerr();
      s_araddr[63:32] = 32'h0000_8000; s_arvalid = 2'b10; s_rready = 2'b10;
      m_rdata = 64'hFFFF_FFFF_FFFF_FFFF; m_arready = 2'b11;
      #1;
      n_assert++; if (s_arready !== 2'b10) begin $display("FAIL decerr_arready got=%b exp=10", s_arready); n_fail++; end
      tick();
      s_arvalid = 2'b00;
      #1;
      n_assert++; if (m_arvalid !== 2'b00) begin $display("FAIL decerr_no_arvalid got=%b exp=00", m_arvalid); n_fail++; end
      n_assert++; if (s_rvalid !== 2'b10 || s_rresp !== 4'b1100 || s_rdata !== 64'h0)
         begin $display("FAIL decerr_r got=%b/%b/%h exp=10/1100/0", s_rvalid, s_rresp, s_rdata); n_fail++; end
      tick();
      n_assert++; if (s_rvalid !== 2'b00 || m_arvalid !== 2'b00 || dut.r_state_q !== R_IDLE)
         begin $display("FAIL decerr_done got=%b/%b/%0d exp=00/00/0", s_rvalid, m_arvalid, dut.r_state_q); n_fail++; end
      clear_inputs();
   endtask

   task automatic test_w_before_aw();
      // W handshakes first; AW is held three cycles before its ready arrives.
      s_awaddr[31:0] = 32'h0000_0008; s_awvalid = 2'b01; s_wvalid = 2'b01;
      s_wdata[31:0] = 32'h1234_5678; s_wstrb[3:0] = 4'h3; m_wready = 2'b01;
      tick();
      s_awvalid = 2'b00;
      #1;
      n_assert++; if (m_wvalid !== 2'b01 || s_wready !== 2'b01) begin $display("FAIL early_w got=%b/%b exp=01/01", m_wvalid, s_wready); n_fail++; end
      tick();
      s_wvalid = 2'b00;
      for (int k = 0; k < 3; k++) begin
         n_assert++; if (m_awvalid !== 2'b01 || m_wvalid !== 2'b00)
            begin $display("FAIL early_hold k=%0d got=%b/%b exp=01/00", k, m_awvalid, m_wvalid); n_fail++; end
         if (k < 2) tick();
      end
      m_awready = 2'b01;
      tick();
      m_awready = 2'b00;
      m_bvalid = 2'b01; s_bready = 2'b01;
      #1;
      n_assert++; if (s_bvalid !== 2'b01) begin $display("FAIL early_b got=%b exp=01", s_bvalid); n_fail++; end
      tick();
      m_bvalid = 2'b00;
      #1;
      n_assert++; if (dut.w_state_q !== W_IDLE || s_bvalid !== 2'b00) begin $display("FAIL early_idle got=%0d/%b exp=0/00", dut.w_state_q, s_bvalid); n_fail++; end
      // AW and W in the same cycle: one FWD cycle, then RESP.
      s_awaddr[31:0] = 32'h0000_1010; s_awvalid = 2'b01; s_wvalid = 2'b01;
      m_awready = 2'b10; m_wready = 2'b10;
      tick();
      s_awvalid = 2'b00;
      tick();
      s_wvalid = 2'b00;
      n_assert++; if (dut.w_state_q !== W_RESP) begin $display("FAIL same_cycle_resp got=%0d exp=2", dut.w_state_q); n_fail++; end
      m_bvalid = 2'b10;
      tick();
      m_bvalid = 2'b00;
      #1;
      n_assert++; if (dut.w_state_q !== W_IDLE || s_bvalid !== 2'b00) begin $display("FAIL same_cycle_idle got=%0d/%b exp=0/00", dut.w_state_q, s_bvalid); n_fail++; end
      clear_inputs();
   endtask

   task automatic test_concurrent();
      m_awready = 2'b11; m_wready = 2'b11; m_arready = 2'b11;
      s_awaddr[31:0] = 32'h0000_0100; s_araddr[31:0] = 32'h0000_1100;
      s_awvalid = 2'b01; s_wvalid = 2'b01; s_arvalid = 2'b01;
      s_bready = 2'b01; s_rready = 2'b01;
      #1;
      n_assert++; if (s_awready !== 2'b01 || s_arready !== 2'b01) begin $display("FAIL conc_grant got=%b/%b exp=01/01", s_awready, s_arready); n_fail++; end
      tick();
      s_awvalid = 2'b00; s_arvalid = 2'b00;
      #1;
      n_assert++; if (m_awvalid !== 2'b01 || m_arvalid !== 2'b10 || m_araddr[63:32] !== 32'h0000_1100)
         begin $display("FAIL conc_fwd got=%b/%b/%h exp=01/10/00001100", m_awvalid, m_arvalid, m_araddr[63:32]); n_fail++; end
      tick();
      s_wvalid = 2'b00;
      m_bvalid = 2'b01; m_rvalid = 2'b10; m_rdata[63:32] = 32'hCAFEF00D; m_rresp = 4'b0000;
      #1;
      n_assert++; if (s_bvalid !== 2'b01 || s_rvalid !== 2'b01 || s_rdata[31:0] !== 32'hCAFEF00D)
         begin $display("FAIL conc_resp got=%b/%b/%h exp=01/01/cafef00d", s_bvalid, s_rvalid, s_rdata[31:0]); n_fail++; end
      tick();
      m_bvalid = 2'b00; m_rvalid = 2'b00;
      n_assert++; if (dut.w_state_q !== W_IDLE || dut.r_state_q !== R_IDLE)
         begin $display("FAIL conc_done got=%0d/%0d exp=0/0", dut.w_state_q, dut.r_state_q); n_fail++; end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      s_awaddr[63:32] = 32'h0000_1000; s_awvalid = 2'b10; s_wvalid = 2'b10;
      m_awready = 2'b10; m_wready = 2'b10;
      tick();
      s_awvalid = 2'b00;
      tick();
      s_wvalid = 2'b00; m_bvalid = 2'b10;
      #1;
      n_assert++; if (s_bvalid !== 2'b10) begin $display("FAIL mid_pending got=%b exp=10", s_bvalid); n_fail++; end
      s_awvalid = 2'b11;
      areset = 1'b1;
      #1;
      n_assert++; if (s_bvalid !== 2'b00 || m_bready !== 2'b00 || s_awready !== 2'b00 || m_awvalid !== 2'b00)
         begin $display("FAIL mid_drop got=%b/%b/%b/%b exp=00/00/00/00", s_bvalid, m_bready, s_awready, m_awvalid); n_fail++; end
      #2;
      areset = 1'b0;
      #1;
      n_assert++; if (s_awready !== 2'b01) begin $display("FAIL mid_first_grant got=%b exp=01", s_awready); n_fail++; end
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_rr_alternate();
      test_read_decerr();
      test_w_before_aw();
      test_concurrent();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_interconnect.md
# axi_lite_interconnect

Parametrised AXI4-Lite N-to-M interconnect for control-plane register traffic. Up to NUM_S upstream masters share NUM_M downstream register slaves. Each port carries a flattened, slot-major bus. It adds the following:
- per-direction round-robin arbitration;
- base/size address decode with internal DECERR responses for unmapped addresses;
- independent write and read engines, each with exactly one transaction in flight.

## Interface
- NUM_S, 2: upstream slots, 1..16.
- NUM_M, 2: downstream slots, 1..16.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width, 32 or 64.
- M_BASE_ADDR, {32'h0000_1000, 32'h0000_0000}: NUM_M*ADDR_WIDTH base addresses, slot 0 in the LSBs.
- M_ADDR_BITS, {32'd12, 32'd12}: NUM_M*32 field. Each entry gives the size of the slot's range as 2^n bytes; the base must be aligned to that size.
- aclk  in  1  sole clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr/awprot/awvalid  in  NUM_S*ADDR_WIDTH / NUM_S*3 / NUM_S; s_axi_awready  out  NUM_S.
- s_axi_wdata/wstrb/wvalid  in  NUM_S*DATA_WIDTH / NUM_S*DATA_WIDTH/8 / NUM_S; s_axi_wready  out  NUM_S.
- s_axi_bresp/bvalid  out  NUM_S*2 / NUM_S; s_axi_bready  in  NUM_S.
- s_axi_araddr/arprot/arvalid  in  as AW; s_axi_arready  out  NUM_S.
- s_axi_rdata/rresp/rvalid  out  NUM_S*DATA_WIDTH / NUM_S*2 / NUM_S; s_axi_rready  in  NUM_S.
- m_axi_* channels: mirror of s_axi_* with NUM_M slots and directions reversed.

## Operation
Write engine states: W_IDLE, W_FWD, W_RESP, W_ERR.
- **W_IDLE**
  - The round-robin arbiter picks a winner among slots with awvalid=1.
  - s_axi_awready[winner]=1 combinationally; every other awready is 0.
  - On the handshake, register awaddr, awprot, winner index and the decoded target.
  - Target matched: go to W_FWD. No range matched: go to W_ERR.
- **W_FWD**
  - m_axi_awvalid[target] is driven from the registers until m_axi_awready is seen.
  - W is a combinational pass-through: m_axi_wvalid[target]=s_axi_wvalid[winner], and s_axi_wready[winner]=m_axi_wready[target], until the W handshake.
  - The AW and W handshakes complete independently, in either order or in the same cycle. Once both are done, go to W_RESP.
- **W_RESP**
  - Pass-through: s_axi_bvalid[winner]=m_axi_bvalid[target], bresp forwarded, m_axi_bready[target]=s_axi_bready[winner].
  - On the B handshake, return to W_IDLE.
- **W_ERR**
  - s_axi_wready[winner]=1 until W is consumed.
  - Then bvalid=1 with bresp=2'b11 (DECERR) until bready; then return to W_IDLE.
  - No downstream signal toggles.

Read engine states: R_IDLE, R_FWD, R_RESP, R_ERR.
- Same structure as the write engine, without a W phase.
- R_ERR returns rdata=0 and rresp=2'b11.

Decode and arbitration rules:
- Decode: slot m matches when (addr >> M_ADDR_BITS[m]) == (M_BASE_ADDR[m] >> M_ADDR_BITS[m]). When ranges overlap, the lowest m wins.
- Arbitration: each engine has its own pointer. The search starts at last_grant+1 and wraps modulo NUM_S. The pointer updates only on an address handshake.
- Write and read engines are fully concurrent. The same upstream slot may hold a write and a read at the same time.
- Unselected slots see ready=0 and valid=0 on every channel.
- Response data is never buffered; the interconnect adds no storage beyond the latched address and indices.

## Timing
- Reset:
  - every *valid and *ready output is 0;
  - m_axi_awaddr, m_axi_araddr and the prot outputs are 0;
  - both engines are in IDLE;
  - both round-robin pointers are NUM_S-1, so slot 0 is checked first;
  - reset is asynchronous in both directions. Assertion mid-transaction abandons the transaction immediately and drops all outputs in the same cycle.
- AW handshake in cycle 0 → m_axi_awvalid is high from cycle 1.
- B or R handshake: 0 added cycles, pass-through.
- Minimum transaction period per engine: 3 cycles (IDLE → FWD → RESP → IDLE), so the next grant is possible in the cycle after the response handshake.
- The engine holds m_axi_awvalid/arvalid until ready; it is never withdrawn.
- A slot that drops awvalid before its grant is legal upstream misuse, and the arbiter ignores it.
- Upstream s_axi_wvalid arriving before AW is granted is not consumed (wready=0).
- NUM_S=1 or NUM_M=1 must elaborate: the arbiter degenerates to a constant and decode to a single compare.

## Structure
- axi_lite_pkg:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the write and read state enums;
  - a function that returns the one-hot address decode.
- Sub-module axi_lite_rr_arbiter:
  - parameter N;
  - inputs req[N], advance;
  - outputs grant_onehot, grant_idx;
  - instantiated twice, once per engine.

## Test plan
- Slot 0 writes 0x0000_1004 with data 0xDEADBEEF → m slot 1 sees awaddr 0x1004, wstrb 0xF; bresp 2'b00 returns to slot 0 only.
- Slots 0 and 1 both hold awvalid continuously for 4 writes → grants alternate 0,1,0,1; slot 0 is first after reset.
- Slot 1 reads 0x0000_8000 (unmapped) → rvalid with rresp 2'b11 and rdata 0; no m_axi_arvalid pulse.
- Write W arrives 3 cycles before m_axi_awready, and a separate case where AW and W complete in the same cycle → exactly one B per write, state returns to W_IDLE.
- Concurrent write to m0 and read from m1 by the same slot → both complete; total ≤4 cycles with zero-wait downstream slaves.
- areset asserted while in W_RESP with bvalid pending → all valid/ready outputs drop at once; the first post-reset grant goes to slot 0.
